// File: rtl/text_buf_pkg.sv
// Shared constants and FSM state type for the UART-to-VGA character buffer.
package text_buf_pkg;

    localparam logic [7:0] CHR_SPACE    = 8'h20;
    localparam logic [7:0] CHR_BS       = 8'h08;
    localparam logic [7:0] CHR_LF       = 8'h0A;
    localparam logic [7:0] CHR_FF       = 8'h0C;
    localparam logic [7:0] CHR_CR       = 8'h0D;
    localparam logic [7:0] CHR_PRINT_LO = 8'h20;
    localparam logic [7:0] CHR_PRINT_HI = 8'h7E;

    typedef enum logic [1:0] {
        CLEAR_ALL = 2'd0,
        IDLE      = 2'd1,
        CLEAR_ROW = 2'd2
    } state_e;

endpackage

// File: rtl/text_ram.sv
// Simple dual-port character RAM: one synchronous write port, one registered read port.
module text_ram #(
    parameter int DEPTH = 128,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rdata_r;

    // Storage array; contents deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read; a same-cell write in this cycle is not yet visible.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_r <= {WIDTH{1'b0}};
        end else begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/uart_text_buffer.sv
// Cursor-driven character grid fed by the UART; wraps or scrolls at the bottom and
// serves scroll-corrected reads to the VGA text generator.
module uart_text_buffer
    import text_buf_pkg::*;
#(
    parameter int COLS   = 32,
    parameter int ROWS   = 4,
    parameter int SCROLL = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    input  logic [$clog2(ROWS)-1:0] rd_row,
    input  logic [$clog2(COLS)-1:0] rd_col,
    output logic [7:0]              rd_data,
    output logic [$clog2(ROWS)-1:0] cursor_row,
    output logic [$clog2(COLS)-1:0] cursor_col,
    output logic                    overflow
);

    localparam int DEPTH = COLS * ROWS;
    localparam int RW    = $clog2(ROWS);
    localparam int CW    = $clog2(COLS);
    localparam int AW    = $clog2(DEPTH);

    state_e          state_r, state_next_s;
    logic [RW-1:0]   row_r, row_next_s, top_r, top_next_s;
    logic [CW-1:0]   col_r, col_next_s;
    logic [AW-1:0]   clr_cnt_r, clr_cnt_next_s;
    logic            rx_ready_r, overflow_r, accept_s, advance_s, we_s;
    logic [AW-1:0]   waddr_s, raddr_s;
    logic [7:0]      wdata_s;

    // Logical row is rotated by the top-row pointer before forming the flat address.
    function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] lrow,
                                                input logic [CW-1:0] col,
                                                input logic [RW-1:0] top);
        logic [RW:0] sum;
        sum = {1'b0, lrow} + {1'b0, top};
        sum = (sum >= (RW+1)'(ROWS)) ? sum - (RW+1)'(ROWS) : sum;
        return AW'(sum) * AW'(COLS) + AW'(col);
    endfunction

    assign accept_s = rx_valid & rx_ready_r;
    assign raddr_s  = cell_addr(rd_row, rd_col, top_r);

    // Next-state, cursor update and RAM write-port control.
    always_comb begin
        state_next_s   = state_r;
        row_next_s     = row_r;
        col_next_s     = col_r;
        top_next_s     = top_r;
        clr_cnt_next_s = clr_cnt_r;
        advance_s      = 1'b0;
        we_s           = 1'b0;
        waddr_s        = cell_addr(row_r, col_r, top_r);
        wdata_s        = CHR_SPACE;
        case (state_r)
            CLEAR_ALL: begin
                we_s    = 1'b1;
                waddr_s = clr_cnt_r;
                if (clr_cnt_r == AW'(DEPTH - 1)) begin
                    clr_cnt_next_s = AW'(0);
                    state_next_s   = IDLE;
                end else begin
                    clr_cnt_next_s = clr_cnt_r + AW'(1);
                end
            end
            CLEAR_ROW: begin
                we_s    = 1'b1;
                waddr_s = cell_addr(RW'(ROWS - 1), clr_cnt_r[CW-1:0], top_r);
                if (clr_cnt_r == AW'(COLS - 1)) begin
                    clr_cnt_next_s = AW'(0);
                    state_next_s   = IDLE;
                end else begin
                    clr_cnt_next_s = clr_cnt_r + AW'(1);
                end
            end
            IDLE: begin
                if (accept_s && rx_data >= CHR_PRINT_LO && rx_data <= CHR_PRINT_HI) begin
                    we_s    = 1'b1;
                    wdata_s = rx_data;
                    if (col_r == CW'(COLS - 1)) begin
                        col_next_s = CW'(0);
                        advance_s  = 1'b1;
                    end else begin
                        col_next_s = col_r + CW'(1);
                    end
                end else if (accept_s) begin
                    case (rx_data)
                        CHR_CR: col_next_s = CW'(0);
                        CHR_LF: begin
                            col_next_s = CW'(0);
                            advance_s  = 1'b1;
                        end
                        CHR_BS: begin
                            if (col_r != CW'(0)) begin
                                col_next_s = col_r - CW'(1);
                                we_s       = 1'b1;
                                waddr_s    = cell_addr(row_r, col_r - CW'(1), top_r);
                            end else begin
                                col_next_s = col_r;
                            end
                        end
                        CHR_FF: begin
                            row_next_s     = RW'(0);
                            col_next_s     = CW'(0);
                            top_next_s     = RW'(0);
                            clr_cnt_next_s = AW'(0);
                            state_next_s   = CLEAR_ALL;
                        end
                        default: col_next_s = col_r;
                    endcase
                end else begin
                    col_next_s = col_r;
                end
            end
            default: begin
                clr_cnt_next_s = AW'(0);
                state_next_s   = CLEAR_ALL;
            end
        endcase

        // Bottom row either wraps the cursor or rotates the grid and blanks the new line.
        if (advance_s && row_r != RW'(ROWS - 1)) begin
            row_next_s = row_r + RW'(1);
        end else if (advance_s && SCROLL == 0) begin
            row_next_s = RW'(0);
        end else if (advance_s) begin
            top_next_s     = (top_r == RW'(ROWS - 1)) ? RW'(0) : top_r + RW'(1);
            clr_cnt_next_s = AW'(0);
            state_next_s   = CLEAR_ROW;
        end else begin
            top_next_s = top_next_s;
        end
    end

    // State, cursor and status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= CLEAR_ALL;
            row_r      <= RW'(0);
            col_r      <= CW'(0);
            top_r      <= RW'(0);
            clr_cnt_r  <= AW'(0);
            rx_ready_r <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            row_r      <= row_next_s;
            col_r      <= col_next_s;
            top_r      <= top_next_s;
            clr_cnt_r  <= clr_cnt_next_s;
            rx_ready_r <= (state_next_s == IDLE);
            overflow_r <= overflow_r | (rx_valid & ~rx_ready_r);
        end
    end

    text_ram #(
        .DEPTH(DEPTH),
        .WIDTH(8)
    ) u_ram (
        .clk  (clk),
        .reset(reset),
        .we   (we_s),
        .waddr(waddr_s),
        .wdata(wdata_s),
        .raddr(raddr_s),
        .rdata(rd_data)
    );

    assign rx_ready   = rx_ready_r;
    assign cursor_row = row_r;
    assign cursor_col = col_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_uart_text_buffer.sv
// Directed bench: one wrapping instance (dut0) and one scrolling instance (dut1).
module tb_uart_text_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data0, rx_data1;
    logic       rx_valid0, rx_valid1;
    logic       rx_ready0, rx_ready1;
    logic [1:0] rd_row;
    logic [4:0] rd_col;
    logic [7:0] rd_data0, rd_data1;
    logic [1:0] cursor_row0, cursor_row1;
    logic [4:0] cursor_col0, cursor_col1;
    logic       overflow0, overflow1;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    uart_text_buffer #(.COLS(32), .ROWS(4), .SCROLL(0)) dut0 (
        .clk(clk), .reset(reset), .rx_data(rx_data0), .rx_valid(rx_valid0),
        .rx_ready(rx_ready0), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data0),
        .cursor_row(cursor_row0), .cursor_col(cursor_col0), .overflow(overflow0)
    );

    uart_text_buffer #(.COLS(32), .ROWS(4), .SCROLL(1)) dut1 (
        .clk(clk), .reset(reset), .rx_data(rx_data1), .rx_valid(rx_valid1),
        .rx_ready(rx_ready1), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data1),
        .cursor_row(cursor_row1), .cursor_col(cursor_col1), .overflow(overflow1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int d);
        return (d == 0) ? rx_ready0 : rx_ready1;
    endfunction

    task automatic drive(input int d, input logic v, input logic [7:0] b);
        if (d == 0) begin
            rx_valid0 = v;
            rx_data0  = b;
        end else begin
            rx_valid1 = v;
            rx_data1  = b;
        end
    endtask

    task automatic wait_ready(input int d, input int limit, output int cycles);
        cycles = 0;
        while (!rdy(d) && cycles < limit) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic send(input int d, input logic [7:0] b);
        int n;
        wait_ready(d, 1000, n);
        check_eq("send_ready", 32'(rdy(d)), 32'd1);
        drive(d, 1'b1, b);
        @(negedge clk);
        drive(d, 1'b0, 8'h00);
    endtask

    task automatic stream(input int d, input logic [7:0] b, input int n, inout int drops);
        for (int i = 0; i < n; i++) begin
            if (!rdy(d)) drops++;
            drive(d, 1'b1, b);
            @(negedge clk);
        end
        drive(d, 1'b0, 8'h00);
    endtask

    task automatic check_cell(input string tag, input int d, input int r, input int c,
                              input logic [7:0] exp);
        logic [7:0] v;
        rd_row = 2'(r);
        rd_col = 5'(c);
        @(negedge clk);
        v = (d == 0) ? rd_data0 : rd_data1;
        check_eq(tag, 32'(v), 32'(exp));
    endtask

    task automatic check_cursor(input string tag, input int d, input int r, input int c);
        if (d == 0) begin
            check_eq({tag, "_row"}, 32'(cursor_row0), 32'(r));
            check_eq({tag, "_col"}, 32'(cursor_col0), 32'(c));
        end else begin
            check_eq({tag, "_row"}, 32'(cursor_row1), 32'(r));
            check_eq({tag, "_col"}, 32'(cursor_col1), 32'(c));
        end
    endtask

    initial begin
        int drops;
        int low;
        logic [7:0] exp;

        reset  = 1'b0;
        rd_row = 2'd0;
        rd_col = 5'd0;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        check_eq("rst_rd_data", 32'(rd_data0), 32'h0);
        check_eq("rst_ready", 32'(rx_ready0), 32'h0);
        check_eq("rst_overflow", 32'(overflow0), 32'h0);
        check_cursor("rst_cursor", 0, 0, 0);

        // Full clear takes 128 cycles after release.
        reset = 1'b1;
        repeat (127) @(negedge clk);
        check_eq("init_ready_127", 32'(rx_ready0), 32'h0);
        @(negedge clk);
        check_eq("init_ready_128", 32'(rx_ready0), 32'h1);
        check_eq("init_ready_128_s", 32'(rx_ready1), 32'h1);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 32; c++) begin
                check_cell("init_blank", 0, r, c, 8'h20);
                check_cell("init_blank_s", 1, r, c, 8'h20);
            end
        check_cursor("init_cursor", 0, 0, 0);
        check_eq("init_overflow", 32'(overflow0), 32'h0);

        // "AB", CR, "C"
        send(0, 8'h41);
        send(0, 8'h42);
        send(0, 8'h0D);
        send(0, 8'h43);
        check_cell("cr_cell00", 0, 0, 0, 8'h43);
        check_cell("cr_cell01", 0, 0, 1, 8'h42);
        check_cell("cr_cell02", 0, 0, 2, 8'h20);
        check_cursor("cr_cursor", 0, 0, 1);

        // Wrap mode: 129 back-to-back 'x' after a form feed.
        send(0, 8'h0C);
        wait_ready(0, 1000, low);
        check_eq("ff_clear_len", 32'(low), 32'd128);
        drops = 0;
        stream(0, 8'h78, 129, drops);
        check_eq("wrap_no_drop", 32'(drops), 32'd0);
        check_eq("wrap_ready", 32'(rx_ready0), 32'h1);
        check_cursor("wrap_cursor", 0, 0, 1);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 32; c++)
                check_cell("wrap_cell", 0, r, c, 8'h78);

        // Backspace, no-op backspace, discarded control, line feed.
        send(0, 8'h0D);
        send(0, 8'h51);
        check_cell("bs_q", 0, 0, 0, 8'h51);
        send(0, 8'h08);
        check_cursor("bs1_cursor", 0, 0, 0);
        send(0, 8'h08);
        check_cursor("bs2_cursor", 0, 0, 0);
        check_cell("bs_cell00", 0, 0, 0, 8'h20);
        check_cell("bs_cell01", 0, 0, 1, 8'h78);
        send(0, 8'h01);
        check_cursor("ctl_cursor", 0, 0, 0);
        check_cell("ctl_cell00", 0, 0, 0, 8'h20);
        send(0, 8'h0A);
        check_cursor("lf_cursor", 0, 1, 0);

        // Scroll mode: four full lines, the last one triggers a 32-cycle row blank.
        drops = 0;
        stream(1, 8'h61, 32, drops);
        stream(1, 8'h62, 32, drops);
        stream(1, 8'h63, 32, drops);
        stream(1, 8'h64, 32, drops);
        check_eq("scroll_no_drop", 32'(drops), 32'd0);
        wait_ready(1, 1000, low);
        check_eq("scroll_low_len", 32'(low), 32'd32);
        send(1, 8'h65);
        check_cursor("scroll_cursor", 1, 3, 1);
        check_eq("scroll_overflow", 32'(overflow1), 32'h0);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 32; c++) begin
                if (r < 3) exp = 8'h62 + 8'(r);
                else if (c == 0) exp = 8'h65;
                else exp = 8'h20;
                check_cell("scroll_cell", 1, r, c, exp);
            end

        // Form feed, then a byte 5 cycles into the clear is dropped.
        send(0, 8'h0C);
        low = 0;
        while (!rx_ready0 && low < 1000) begin
            drive(0, (low == 5), 8'h5A);
            @(negedge clk);
            low++;
        end
        drive(0, 1'b0, 8'h00);
        check_eq("ff_low_len", 32'(low), 32'd128);
        check_eq("ovf_set", 32'(overflow0), 32'h1);
        check_cursor("ovf_cursor", 0, 0, 0);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 32; c++)
                check_cell("ovf_blank", 0, r, c, 8'h20);
        check_eq("ovf_held", 32'(overflow0), 32'h1);
        check_eq("ovf_other", 32'(overflow1), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
